// File: rtl/calculator_core.sv
// Calculator datapath: single-cycle add/sub, WIDTH-iteration shift-add multiply
// and restoring divide, framed by an in_valid/in_ready accept and an out_valid pulse.
module calculator_core #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   dat_a_in,
    input  logic [WIDTH-1:0]   dat_b_in,
    input  logic [1:0]         function_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               out_valid,
    output logic               err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               err_q, err_d;

    // Single-cycle results computed straight from the live operand inputs.
    logic [2*WIDTH-1:0] sum_w;
    logic [2*WIDTH-1:0] diff_w;

    assign sum_w  = {{WIDTH{1'b0}}, dat_a_in} + {{WIDTH{1'b0}}, dat_b_in};
    assign diff_w = {{WIDTH{1'b0}}, dat_a_in} - {{WIDTH{1'b0}}, dat_b_in};

    // One multiply iteration: add A shifted by the current bit position of B.
    logic               last_iter;
    logic [2*WIDTH-1:0] addend_w;
    logic [2*WIDTH-1:0] mul_acc_w;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));
    assign addend_w  = b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0;
    assign mul_acc_w = acc_q + addend_w;

    // One restoring-divide iteration, dividend bits consumed MSB first.
    logic [CW-1:0]      bit_idx;
    logic [WIDTH:0]     trial_w;
    logic [WIDTH:0]     trial_sub_w;
    logic               fits_w;
    logic [WIDTH-1:0]   rem_next_w;
    logic [WIDTH-1:0]   quot_next_w;

    assign bit_idx     = CW'(WIDTH - 1) - cnt_q;
    assign trial_w     = {rem_q, a_q[bit_idx]};
    assign trial_sub_w = trial_w - {1'b0, b_q};
    assign fits_w      = (trial_w >= {1'b0, b_q});
    assign rem_next_w  = fits_w ? trial_sub_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
    assign quot_next_w = {quot_q[WIDTH-2:0], fits_w};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        out_d   = out_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d    = dat_a_in;
                    b_d    = dat_b_in;
                    op_d   = function_in;
                    cnt_d  = '0;
                    acc_d  = '0;
                    rem_d  = '0;
                    quot_d = '0;
                    if (function_in == OP_ADD || function_in == OP_SUB) begin
                        out_d   = (function_in == OP_SUB) ? diff_w : sum_w;
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc_w;
                end else begin
                    rem_d  = rem_next_w;
                    quot_d = quot_next_w;
                end
                cnt_d = cnt_q + CW'(1);

                if (last_iter) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                    if (op_q == OP_MUL) begin
                        out_d = mul_acc_w;
                        err_d = 1'b0;
                    end else if (op_q == OP_DIV && b_q == '0) begin
                        // Divide by zero still runs the full iteration count.
                        out_d = '1;
                        err_d = 1'b1;
                    end else begin
                        out_d = {rem_next_w, quot_next_w};
                        err_d = 1'b0;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            out_q   <= out_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out       = out_q;
    assign err       = err_q;

endmodule
